// File: rtl/bus_pkg.sv
// Shared types for the bus generator/arbiter: state encoding and
// destination-ID extraction from a packet.
package bus_pkg;

    localparam int ID_W    = 8;
    localparam int PKT_MAX = 256;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DELIVER
    } state_t;

    // Destination ID sits in the top ID_W bits of a width-bit packet.
    // The packet is passed zero-extended to PKT_MAX bits.
    function automatic logic [ID_W-1:0] dest_id(
        input logic [PKT_MAX-1:0] pkt,
        input int                 width
    );
        return pkt[width-1 -: ID_W];
    endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// One bus: round-robin grant, single-packet pop, push decode.
// Ports: clk, reset (sync, high), pndng/d_pop in, pop/push/d_push out.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   d_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   d_push
);

    localparam int IW = $clog2(drvrs);

    state_t               state, nxt;
    logic [IW-1:0]        g_q, g_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [drvrs-1:0]     pop_q, pop_d;
    logic [drvrs-1:0]     push_q, push_d;
    logic [pckg_sz-1:0]   pkt_q, pkt_d;
    logic [ID_W-1:0]      dst;
    logic                 found;

    always_comb begin
        nxt    = state;
        g_d    = g_q;
        rr_d   = rr_q;
        pop_d  = '0;
        push_d = '0;
        pkt_d  = pkt_q;
        dst    = '0;
        found  = 1'b0;
        unique case (state)
            IDLE: begin
                // Search rr..drvrs-1 first, then wrap to 0..rr-1.
                for (int j = 0; j < drvrs; j++) begin
                    if (!found && j >= int'(rr_q) && pndng[j]) begin
                        found    = 1'b1;
                        g_d      = IW'(j);
                        pop_d[j] = 1'b1;
                    end
                end
                for (int j = 0; j < drvrs; j++) begin
                    if (!found && j < int'(rr_q) && pndng[j]) begin
                        found    = 1'b1;
                        g_d      = IW'(j);
                        pop_d[j] = 1'b1;
                    end
                end
                if (found) nxt = POP;
            end
            POP: begin
                // Packet is captured as the terminal dequeues it; the
                // push strobes are decoded now so they are registered.
                pkt_d = d_pop[g_q];
                dst   = dest_id(PKT_MAX'(d_pop[g_q]), pckg_sz);
                for (int j = 0; j < drvrs; j++) begin
                    if (dst == broadcast)
                        push_d[j] = (j != int'(g_q));
                    else
                        push_d[j] = (int'(dst) == j);
                end
                nxt = DELIVER;
            end
            DELIVER: begin
                if (g_q == IW'(drvrs - 1))
                    rr_d = '0;
                else
                    rr_d = g_q + IW'(1);
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            g_q    <= '0;
            rr_q   <= '0;
            pop_q  <= '0;
            push_q <= '0;
            pkt_q  <= '0;
        end else begin
            state  <= nxt;
            g_q    <= g_d;
            rr_q   <= rr_d;
            pop_q  <= pop_d;
            push_q <= push_d;
            pkt_q  <= pkt_d;
        end
    end

    assign pop  = pop_q;
    assign push = push_q;

    always_comb begin
        for (int j = 0; j < drvrs; j++)
            d_push[j] = pkt_q;
    end

endmodule

// File: rtl/bus_generator_n_arbiter.sv
// Shared-bus generator: one round-robin arbiter per bus.
// Ports: clk, reset, pndng/D_pop per terminal in; pop/push/D_push out.
module bus_generator_n_arbiter
    import bus_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [bits-1:0][drvrs-1:0]               pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
    output logic [bits-1:0][drvrs-1:0]               pop,
    output logic [bits-1:0][drvrs-1:0]               push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

    for (genvar b = 0; b < bits; b++) begin : g_bus
        bus_arbiter_rr #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_arb (
            .clk    (clk),
            .reset  (reset),
            .pndng  (pndng[b]),
            .d_pop  (D_pop[b]),
            .pop    (pop[b]),
            .push   (push[b]),
            .d_push (D_push[b])
        );
    end

endmodule

// File: tb/tb_bus_generator_n_arbiter.sv
// Directed bench for bus_generator_n_arbiter (1 bus, 5 terminals).
module tb_bus_generator_n_arbiter;

    localparam int BITS = 1;
    localparam int DRV  = 5;
    localparam int PSZ  = 16;

    logic                             clk = 1'b0;
    logic                             reset = 1'b1;
    logic [BITS-1:0][DRV-1:0]         pndng = '0;
    logic [BITS-1:0][DRV-1:0][PSZ-1:0] D_pop = '0;
    logic [BITS-1:0][DRV-1:0]         pop;
    logic [BITS-1:0][DRV-1:0]         push;
    logic [BITS-1:0][DRV-1:0][PSZ-1:0] D_push;

    int checks = 0;
    int failures = 0;

    bus_generator_n_arbiter #(
        .bits      (BITS),
        .drvrs     (DRV),
        .pckg_sz   (PSZ),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DRV-1:0] exp_pop [4];
    logic [DRV-1:0] exp_push [4];

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_pop", 32'(pop[0]), 32'h0);
        chk("rst_push", 32'(push[0]), 32'h0);
        chk("rst_dpush", 32'(D_push[0][0]), 32'h0);
        reset = 1'b0;

        // Unicast 1 -> 3
        pndng[0][1] = 1'b1;
        D_pop[0][1] = 16'h03AB;
        tick();
        chk("uni_pop", 32'(pop[0]), 32'h02);
        chk("uni_pop_push", 32'(push[0]), 32'h0);
        tick();
        chk("uni_push", 32'(push[0]), 32'h08);
        chk("uni_push_pop", 32'(pop[0]), 32'h0);
        chk("uni_data0", 32'(D_push[0][0]), 32'h03AB);
        chk("uni_data4", 32'(D_push[0][4]), 32'h03AB);
        pndng[0][1] = 1'b0;
        tick();
        chk("uni_idle_push", 32'(push[0]), 32'h0);
        chk("uni_hold", 32'(D_push[0][2]), 32'h03AB);

        // Broadcast from 2 (rr now 2)
        pndng[0][2] = 1'b1;
        D_pop[0][2] = 16'hFF55;
        tick();
        chk("bc_pop", 32'(pop[0]), 32'h04);
        tick();
        chk("bc_push", 32'(push[0]), 32'h1B);
        chk("bc_data", 32'(D_push[0][1]), 32'hFF55);
        pndng[0][2] = 1'b0;
        tick();
        chk("bc_end", 32'(push[0]), 32'h0);

        // Self-addressed from 3 (rr now 3)
        pndng[0][3] = 1'b1;
        D_pop[0][3] = 16'h0312;
        tick();
        chk("self_pop", 32'(pop[0]), 32'h08);
        tick();
        chk("self_push", 32'(push[0]), 32'h08);
        chk("self_data", 32'(D_push[0][3]), 32'h0312);
        pndng[0][3] = 1'b0;
        tick();

        // Invalid destination from 0 (rr now 4, wraps to 0)
        pndng[0][0] = 1'b1;
        D_pop[0][0] = 16'h07AA;
        tick();
        chk("inv_pop", 32'(pop[0]), 32'h01);
        tick();
        chk("inv_push", 32'(push[0]), 32'h0);
        chk("inv_data", 32'(D_push[0][0]), 32'h07AA);
        pndng[0][0] = 1'b0;
        tick();
        chk("inv_idle", 32'(pop[0] | push[0]), 32'h0);

        // rr must be 1: with 0 and 1 pending, 1 wins
        pndng[0][0] = 1'b1;
        pndng[0][1] = 1'b1;
        D_pop[0][1] = 16'h0011;
        tick();
        chk("rr1_pop", 32'(pop[0]), 32'h02);
        tick();
        chk("rr1_push", 32'(push[0]), 32'h01);
        chk("rr1_data", 32'(D_push[0][0]), 32'h0011);
        pndng[0] = '0;
        tick();

        // Round-robin contention after reset: 0,2,4,0
        reset = 1'b1;
        tick();
        chk("rst2_pop", 32'(pop[0] | push[0]), 32'h0);
        reset = 1'b0;
        D_pop[0][0] = 16'h0100;
        D_pop[0][2] = 16'h0300;
        D_pop[0][4] = 16'h0000;
        pndng[0] = 5'b10101;
        exp_pop  = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
        exp_push = '{5'b00010, 5'b01000, 5'b00001, 5'b00010};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_pop%0d", k), 32'(pop[0]),
                32'(exp_pop[k]));
            tick();
            chk($sformatf("rr_push%0d", k), 32'(push[0]),
                32'(exp_push[k]));
            tick();
            chk($sformatf("rr_gap%0d", k), 32'(pop[0] | push[0]),
                32'h0);
        end

        // Reset during POP (rr is 1, so 3 wins)
        pndng[0] = 5'b01000;
        D_pop[0][3] = 16'h0222;
        tick();
        chk("mid_pop", 32'(pop[0]), 32'h08);
        reset = 1'b1;
        tick();
        chk("mid_rst_pop", 32'(pop[0]), 32'h0);
        chk("mid_rst_push", 32'(push[0]), 32'h0);
        chk("mid_rst_data", 32'(D_push[0][0]), 32'h0);
        reset = 1'b0;
        pndng[0] = 5'b01001;
        D_pop[0][0] = 16'h0244;
        tick();
        chk("post_pop", 32'(pop[0]), 32'h01);
        tick();
        chk("post_push", 32'(push[0]), 32'h04);
        chk("post_data", 32'(D_push[0][2]), 32'h0244);
        pndng[0] = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
